// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if: ALU <-> divider request/response bundle.
//   start_div  : division request, held by the ALU until div_ready
//   signed_div : 1 = DIV (two's complement), 0 = DIVU
//   opdata1    : dividend (rs)
//   opdata2    : divisor (rt)
//   annul      : flush/exception cancel
//   result     : {remainder, quotient}
//   div_ready  : result valid
//   busy       : division in progress
// master = ALU side, slave = divider side.
// -----------------------------------------------------------------------------
interface div_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  start_div;
    logic                  signed_div;
    logic [DATA_W-1:0]     opdata1;
    logic [DATA_W-1:0]     opdata2;
    logic                  annul;
    logic [2*DATA_W-1:0]   result;
    logic                  div_ready;
    logic                  busy;

    modport master (
        output start_div, signed_div, opdata1, opdata2, annul,
        input  result, div_ready, busy
    );

    modport slave (
        input  start_div, signed_div, opdata1, opdata2, annul,
        output result, div_ready, busy
    );
endinterface

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit: multi-cycle restoring divider for DIV / DIVU.
// One quotient bit is produced per clock; signed operation divides the
// magnitudes and fixes the signs of quotient and remainder at the end.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : div_if slave modport (start_div, signed_div, opdata1, opdata2,
//         annul in; result, div_ready, busy out)
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    div_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV_ZERO,
        ON,
        END
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W:0]     rem;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   divisor;
    logic [CNT_W-1:0]    cnt;
    logic                neg_q;
    logic                neg_r;

    logic                start_ok;
    logic [DATA_W+1:0]   trial;
    logic                trial_ok;
    logic [DATA_W:0]     rem_nxt;
    logic [DATA_W-1:0]   quo_nxt;
    logic [DATA_W-1:0]   q_out;
    logic [DATA_W-1:0]   r_out;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic          is_signed);
        // Most negative value maps onto itself, which is its correct
        // unsigned magnitude.
        if (is_signed && v[DATA_W-1]) begin
            return -v;
        end
        return v;
    endfunction

    assign start_ok = bus.start_div && !bus.annul;

    // One restoring step: shift the next dividend bit into rem, then try
    // to subtract the divisor; the borrow bit decides the quotient bit.
    always_comb begin
        trial    = {1'b0, rem[DATA_W-1:0], quo[DATA_W-1]} - {2'b00, divisor};
        trial_ok = !trial[DATA_W+1] && !rem[DATA_W];
        rem_nxt  = trial_ok ? trial[DATA_W:0] : {rem[DATA_W-1:0], quo[DATA_W-1]};
        quo_nxt  = {quo[DATA_W-2:0], trial_ok};
        q_out    = neg_q ? -quo_nxt : quo_nxt;
        r_out    = neg_r ? -rem_nxt[DATA_W-1:0] : rem_nxt[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = (bus.opdata2 == '0) ? DIV_ZERO : ON;
                end
            end
            DIV_ZERO: begin
                state_nxt = start_ok ? END : IDLE;
            end
            ON: begin
                if (!start_ok) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST_STEP) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (bus.annul || !bus.start_div) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result <= '0;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        rem     <= '0;
                        quo     <= magnitude(bus.opdata1, bus.signed_div);
                        divisor <= magnitude(bus.opdata2, bus.signed_div);
                        cnt     <= '0;
                        neg_q   <= bus.signed_div &&
                                   (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
                        neg_r   <= bus.signed_div && bus.opdata1[DATA_W-1];
                    end
                end
                DIV_ZERO: begin
                    if (start_ok) begin
                        bus.result <= '0;
                    end
                end
                ON: begin
                    // Aborted operations leave the previous result untouched.
                    if (start_ok) begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_STEP) begin
                            bus.result <= {r_out, q_out};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.div_ready = (state == END);
    assign bus.busy      = (state == DIV_ZERO) || (state == ON);

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit: self-checking bench for div_unit.
// A transaction-level model (operation latency plus plain integer division)
// predicts div_ready / busy / result every cycle; directed cases pin the
// model with hand-computed literals, then randomized operations follow.
// -----------------------------------------------------------------------------
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    div_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating division, remainder takes dividend sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input bit s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Cycle-level expectation: an operation takes 32 edges after the start
    // edge (1 for a zero divisor), aborts on annul or a dropped request.
    logic [63:0] exp_result = '0;
    logic        exp_ready  = 1'b0;
    logic        exp_busy   = 1'b0;
    logic [63:0] m_pending  = '0;
    int          m_left     = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_left     = 0;
            exp_ready  = 1'b0;
            exp_busy   = 1'b0;
            exp_result = '0;
        end else if (exp_ready) begin
            if (bus.annul || !bus.start_div) exp_ready = 1'b0;
        end else if (m_left > 0) begin
            if (bus.annul || !bus.start_div) begin
                m_left   = 0;
                exp_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    exp_ready  = 1'b1;
                    exp_busy   = 1'b0;
                    exp_result = m_pending;
                end
            end
        end else if (bus.start_div && !bus.annul) begin
            m_pending = ref_div(bus.opdata1, bus.opdata2, bus.signed_div);
            m_left    = (bus.opdata2 == 32'd0) ? 1 : 32;
            exp_busy  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_ready",  {63'd0, bus.div_ready}, {63'd0, exp_ready});
            check("cyc_busy",   {63'd0, bus.busy},      {63'd0, exp_busy});
            check("cyc_result", bus.result,             exp_result);
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input int hold, input bit pin, input logic [63:0] lit);
        int          edges;
        int          want;
        logic [63:0] got;
        want = (b == 32'd0) ? 2 : 33;
        @(posedge clk); #2;
        bus.start_div  = 1'b1;
        bus.signed_div = s;
        bus.opdata1    = a;
        bus.opdata2    = b;
        edges = 0;
        while (edges < 60) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.div_ready) break;
            if (edges == 1) begin
                // Operands are only sampled on the start edge.
                #1;
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.signed_div = 1'($urandom);
            end
        end
        check("latency", 64'(edges), 64'(want));
        got = bus.result;
        if (pin) check("result_lit", got, lit);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("held_ready",  {63'd0, bus.div_ready}, 64'd1);
            check("held_result", bus.result, got);
        end
        #1;
        bus.start_div = 1'b0;
        @(posedge clk); #1;
        check("drop_ready", {63'd0, bus.div_ready}, 64'd0);
    endtask

    task automatic abort_op(input bit use_rst, input int at);
        @(posedge clk); #2;
        bus.start_div  = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd3;
        @(posedge clk);
        repeat (at) @(posedge clk);
        #2;
        if (use_rst) rst = 1'b1;
        else         bus.annul = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",  {63'd0, bus.busy},      64'd0);
        check("abort_ready", {63'd0, bus.div_ready}, 64'd0);
        if (use_rst) check("abort_rst_result", bus.result, 64'd0);
        #1;
        rst           = 1'b0;
        bus.annul     = 1'b0;
        bus.start_div = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bus.start_div  = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        bus.annul      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_result", bus.result, 64'd0);
        check("rst_ready",  {63'd0, bus.div_ready}, 64'd0);
        check("rst_busy",   {63'd0, bus.busy}, 64'd0);
        #1;
        rst = 1'b0;
        check_en = 1'b1;

        do_op(32'd7,          32'd2,          1'b0, 5, 1'b1, 64'h00000001_00000003);
        do_op(32'hFFFFFFF9,   32'd2,          1'b1, 0, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
        do_op(32'hFFFFFFF9,   32'd2,          1'b0, 1, 1'b1, 64'h00000001_7FFFFFFC);
        do_op(32'h80000000,   32'hFFFFFFFF,   1'b1, 0, 1'b1, 64'h00000000_80000000);
        do_op(32'h00001234,   32'd0,          1'b1, 0, 1'b1, 64'h00000000_00000000);

        abort_op(1'b0, 10);
        do_op(32'd100, 32'd7, 1'b0, 0, 1'b1, 64'h00000002_0000000E);
        abort_op(1'b1, 20);

        // Request together with annul in IDLE must not start anything.
        @(posedge clk); #2;
        bus.start_div = 1'b1;
        bus.annul     = 1'b1;
        bus.opdata1   = 32'd9;
        bus.opdata2   = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        check("start_annul_busy", {63'd0, bus.busy}, 64'd0);
        #1;
        bus.start_div = 1'b0;
        bus.annul     = 1'b0;

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 16);
                3:       b = 32'hFFFFFFFF;
                4:       b = -($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            do_op(a, b, 1'($urandom), $urandom_range(0, 2), 1'b0, 64'd0);
        end

        repeat (2) @(posedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
